// File: rtl/bcd_scan_pkg.sv
// rtl/bcd_scan_pkg.sv - shared constants and helpers for the BCD page scanner
//
// Purpose: blank digit code, active-low hex glyph table (bit6=g .. bit0=a)
//          and a constant-evaluable ceil(log2) helper.
// Ports:   none (package).
package bcd_scan_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int clog2(input int value);
        int bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debouncer and press detector
//
// Purpose: brings the raw active-low button into the CLOCK_50 domain with two
//          flops, accepts a new level only after it has been stable for
//          DEBOUNCE_TICKS consecutive cycles, and pulses press for one cycle
//          on each accepted 1->0 transition (the cycle after the change).
// Ports:   CLOCK_50 (in)  clock
//          reset_n  (in)  asynchronous active-low reset
//          btn_n    (in)  raw active-low button
//          press    (out) one-cycle pulse per debounced press
module btn_debounce
    import bcd_scan_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 500_000
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (clog2(DEBOUNCE_TICKS) < 1) ? 1 : clog2(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
        end else begin
            sync_q1 <= btn_n;
            sync_q2 <= sync_q1;
            level_d <= level;
            // Any cycle where the synchronized input agrees with the accepted
            // level counts as a bounce and restarts the stability count.
            if (sync_q2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_q2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level_d & ~level;

endmodule

// File: rtl/bcd_page_scanner.sv
// rtl/bcd_page_scanner.sv - pages a long BCD number across a short display
//
// Purpose: every PAGE_TICKS cycles (unless scan_hold) steps to the next page,
//          most significant page first, and latches that page's digits.
//          A debounced button toggles run. Optional macro
//          LEADING_ZERO_BLANK_EN blanks digits above the highest nonzero one.
// Ports:   CLOCK_50    (in)  clock
//          reset_n     (in)  asynchronous active-low reset
//          bcd_in      (in)  4*NUM_DIGITS, digit k at [4k+3:4k]
//          btn_n       (in)  raw active-low start/stop button
//          scan_hold   (in)  freezes the page timer
//          disp_bcd    (out) 4*DISP_DIGITS registered page digits, 4'hF blank
//          page_idx    (out) PW current page
//          page_seg    (out) 7 active-low glyph of page_idx
//          run         (out) start/stop toggle
//          page_strobe (out) one-cycle pulse per page change
module bcd_page_scanner
    import bcd_scan_pkg::*;
#(
    parameter  int NUM_DIGITS     = 11,
    parameter  int DISP_DIGITS    = 3,
    parameter  int PAGE_TICKS     = 50_000_000,
    parameter  int DEBOUNCE_TICKS = 500_000,
    localparam int PAGES          = (NUM_DIGITS + DISP_DIGITS - 1) / DISP_DIGITS,
    localparam int PW             = (clog2(PAGES) < 1) ? 1 : clog2(PAGES)
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    input  logic [4*NUM_DIGITS-1:0]  bcd_in,
    input  logic                     btn_n,
    input  logic                     scan_hold,
    output logic [4*DISP_DIGITS-1:0] disp_bcd,
    output logic [PW-1:0]            page_idx,
    output logic [6:0]               page_seg,
    output logic                     run,
    output logic                     page_strobe
);

    localparam int TW = (clog2(PAGE_TICKS) < 1) ? 1 : clog2(PAGE_TICKS);
    localparam logic [TW-1:0] TERM = TW'(PAGE_TICKS - 1);
    localparam logic [PW-1:0] LAST_PAGE = PW'(PAGES - 1);
    // Slot table spans every encodable page so the page mux never reads
    // outside it; slots past NUM_DIGITS stay blank.
    localparam int PAGE_SPAN = 1 << PW;
    localparam int SLOTS = PAGE_SPAN * DISP_DIGITS;

    logic [TW-1:0]            timer;
    logic [PW-1:0]            next_page;
    logic [3:0]               padded [SLOTS];
    logic [4*DISP_DIGITS-1:0] next_disp;
    logic                     advance;
    logic                     press;
`ifdef LEADING_ZERO_BLANK_EN
    int                       top_digit;
`endif

    btn_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_btn (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .btn_n   (btn_n),
        .press   (press)
    );

    // Hold wins over a coincident terminal count.
    assign advance   = (timer == TERM) && !scan_hold;
    assign next_page = (page_idx == '0) ? LAST_PAGE : page_idx - PW'(1);

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        top_digit = 0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_in[4*k +: 4] != 4'h0) begin
                top_digit = k;
            end
        end
`endif
        for (int k = 0; k < SLOTS; k++) begin
            padded[k] = BLANK_CODE;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            padded[k] = bcd_in[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            // Digit 0 is never above top_digit, so zero still shows as "0".
            if (k > top_digit) begin
                padded[k] = BLANK_CODE;
            end
`endif
        end
    end

    always_comb begin
        next_disp = '1;
        for (int p = 0; p < PAGE_SPAN; p++) begin
            if (next_page == PW'(p)) begin
                for (int j = 0; j < DISP_DIGITS; j++) begin
                    next_disp[4*j +: 4] = padded[p*DISP_DIGITS + j];
                end
            end
        end
    end

    always_comb begin
        page_seg = 7'h7F;
        for (int v = 0; v < 16; v++) begin
            if (int'(page_idx) == v) begin
                page_seg = SEG_TABLE[v];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            timer       <= '0;
            page_idx    <= '0;
            disp_bcd    <= '1;
            page_strobe <= 1'b0;
            run         <= 1'b1;
        end else begin
            page_strobe <= advance;
            if (!scan_hold) begin
                timer <= (timer == TERM) ? '0 : timer + TW'(1);
            end
            if (advance) begin
                page_idx <= next_page;
                disp_bcd <= next_disp;
            end
            if (press) begin
                run <= ~run;
            end
        end
    end

endmodule

// File: tb/tb_bcd_page_scanner.sv
// tb/tb_bcd_page_scanner.sv - self-checking bench for bcd_page_scanner
//
// Purpose: table of page-scan vectors plus directed hold, button, reset and
//          single-tick sequences. Expectations follow LEADING_ZERO_BLANK_EN.
// Ports:   none (bench top).
module tb_bcd_page_scanner;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        btn_n;
    logic        scan_hold;
    logic        hold1;
    logic [43:0] bcd_in;
    logic [11:0] disp_bcd;
    logic [11:0] d1_disp;
    logic [1:0]  page_idx;
    logic [1:0]  d1_idx;
    logic [6:0]  page_seg;
    logic [6:0]  d1_seg;
    logic        run;
    logic        d1_run;
    logic        page_strobe;
    logic        d1_strobe;
    int          checks = 0;
    int          failures = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    bcd_page_scanner #(
        .NUM_DIGITS(11), .DISP_DIGITS(3), .PAGE_TICKS(4), .DEBOUNCE_TICKS(3)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .bcd_in(bcd_in), .btn_n(btn_n),
        .scan_hold(scan_hold), .disp_bcd(disp_bcd), .page_idx(page_idx),
        .page_seg(page_seg), .run(run), .page_strobe(page_strobe)
    );

    bcd_page_scanner #(
        .NUM_DIGITS(11), .DISP_DIGITS(3), .PAGE_TICKS(1), .DEBOUNCE_TICKS(3)
    ) dut1 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .bcd_in(bcd_in), .btn_n(1'b1),
        .scan_hold(hold1), .disp_bcd(d1_disp), .page_idx(d1_idx),
        .page_seg(d1_seg), .run(d1_run), .page_strobe(d1_strobe)
    );

    typedef struct {
        logic [43:0] bcd;
        logic [1:0]  idx;
        logic [11:0] disp;
        logic [6:0]  seg;
    } vec_t;

    vec_t vt [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_strobe(output int gap);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!page_strobe && gap < 40);
    endtask

    initial begin
        int          gap;
        logic [11:0] prev;
        logic        seen;
        logic [1:0]  seq1 [5];

        seq1 = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

        vt[0]  = '{44'hA9876543210, 2'd3, 12'hFA9, 7'h30};
        vt[1]  = '{44'hA9876543210, 2'd2, 12'h876, 7'h24};
        vt[2]  = '{44'hA9876543210, 2'd1, 12'h543, 7'h79};
        vt[3]  = '{44'hA9876543210, 2'd0, 12'h210, 7'h40};
        vt[4]  = '{44'hA9876543210, 2'd3, 12'hFA9, 7'h30};
`ifdef LEADING_ZERO_BLANK_EN
        vt[5]  = '{44'h42, 2'd2, 12'hFFF, 7'h24};
        vt[6]  = '{44'h42, 2'd1, 12'hFFF, 7'h79};
        vt[7]  = '{44'h42, 2'd0, 12'hF42, 7'h40};
        vt[8]  = '{44'h0,  2'd3, 12'hFFF, 7'h30};
        vt[9]  = '{44'h0,  2'd2, 12'hFFF, 7'h24};
        vt[10] = '{44'h0,  2'd1, 12'hFFF, 7'h79};
        vt[11] = '{44'h0,  2'd0, 12'hFF0, 7'h40};
`else
        vt[5]  = '{44'h42, 2'd2, 12'h000, 7'h24};
        vt[6]  = '{44'h42, 2'd1, 12'h000, 7'h79};
        vt[7]  = '{44'h42, 2'd0, 12'h042, 7'h40};
        vt[8]  = '{44'h0,  2'd3, 12'hF00, 7'h30};
        vt[9]  = '{44'h0,  2'd2, 12'h000, 7'h24};
        vt[10] = '{44'h0,  2'd1, 12'h000, 7'h79};
        vt[11] = '{44'h0,  2'd0, 12'h000, 7'h40};
`endif

        reset_n   = 1'b0;
        btn_n     = 1'b1;
        scan_hold = 1'b0;
        hold1     = 1'b1;
        bcd_in    = vt[0].bcd;
        tick();
        tick();
        check("reset_idx",    64'(page_idx),    64'd0);
        check("reset_disp",   64'(disp_bcd),    64'hFFF);
        check("reset_strobe", 64'(page_strobe), 64'd0);
        check("reset_run",    64'(run),         64'd1);
        check("reset_seg",    64'(page_seg),    64'h40);
        check("reset_d1_seg", 64'(d1_seg),      64'h40);
        check("reset_d1_run", 64'(d1_run),      64'd1);
        reset_n = 1'b1;

        // Page scan table: each row waits for the next strobe.
        prev = 12'hFFF;
        for (int i = 0; i < 12; i++) begin
            bcd_in = vt[i].bcd;
            gap = 0;
            do begin
                tick();
                gap++;
                if (gap == 1) check("disp_stable_between", 64'(disp_bcd), 64'(prev));
            end while (!page_strobe && gap < 40);
            check("scan_gap",  64'(gap),      64'd4);
            check("scan_idx",  64'(page_idx), 64'(vt[i].idx));
            check("scan_disp", 64'(disp_bcd), 64'(vt[i].disp));
            check("scan_seg",  64'(page_seg), 64'(vt[i].seg));
            prev = vt[i].disp;
        end

        // Hold at timer=2 for 10 cycles, then resume.
        bcd_in = 44'hA9876543210;
        tick();
        tick();
        scan_hold = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (page_strobe) seen = 1'b1;
        end
        check("hold_no_strobe", 64'(seen),     64'd0);
        check("hold_idx",       64'(page_idx), 64'd0);
        scan_hold = 1'b0;
        wait_strobe(gap);
        check("hold_resume_gap",  64'(gap),      64'd2);
        check("hold_resume_idx",  64'(page_idx), 64'd3);
        check("hold_resume_disp", 64'(disp_bcd), 64'hFA9);

        // Hold coinciding with terminal count.
        tick();
        tick();
        tick();
        scan_hold = 1'b1;
        tick();
        check("hold_tc_strobe", 64'(page_strobe), 64'd0);
        check("hold_tc_idx",    64'(page_idx),    64'd3);
        scan_hold = 1'b0;
        tick();
        check("after_tc_strobe", 64'(page_strobe), 64'd1);
        check("after_tc_idx",    64'(page_idx),    64'd2);
        check("after_tc_disp",   64'(disp_bcd),    64'h876);

        // PAGE_TICKS=1 instance: strobe on every unheld cycle.
        check("d1_held_strobe", 64'(d1_strobe), 64'd0);
        check("d1_held_idx",    64'(d1_idx),    64'd0);
        hold1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("d1_strobe", 64'(d1_strobe), 64'd1);
            check("d1_idx",    64'(d1_idx),    64'(seq1[i]));
            if (i == 0) check("d1_disp", 64'(d1_disp), 64'hFA9);
        end
        hold1 = 1'b1;
        tick();
        check("d1_rehold_strobe", 64'(d1_strobe), 64'd0);
        check("d1_rehold_idx",    64'(d1_idx),    64'd3);

        // Short glitch must not toggle run.
        btn_n = 1'b0;
        tick();
        tick();
        btn_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!run) seen = 1'b1;
        end
        check("glitch_run", 64'(seen), 64'd0);

        // Real press: run toggles on the 6th edge, release does nothing.
        btn_n = 1'b0;
        repeat (5) tick();
        check("press_run_before", 64'(run), 64'd1);
        tick();
        check("press_run_after", 64'(run), 64'd0);
        btn_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (run) seen = 1'b1;
        end
        check("release_run", 64'(seen), 64'd0);

        // Reset mid-page at page 1 with a press partly debounced.
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!(page_strobe && page_idx == 2'd1) && gap < 40);
        check("reach_page1", 64'(page_idx), 64'd1);
        btn_n = 1'b0;
        tick();
        tick();
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_idx",    64'(page_idx),    64'd0);
        check("async_rst_disp",   64'(disp_bcd),    64'hFFF);
        check("async_rst_run",    64'(run),         64'd1);
        check("async_rst_strobe", 64'(page_strobe), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (page_strobe) seen = 1'b1;
        end
        check("post_rst_early_strobe", 64'(seen), 64'd0);
        tick();
        check("post_rst_strobe", 64'(page_strobe), 64'd1);
        check("post_rst_idx",    64'(page_idx),    64'd3);
        check("post_rst_disp",   64'(disp_bcd),    64'hFA9);
        tick();
        check("post_rst_run_before", 64'(run), 64'd1);
        tick();
        check("post_rst_run_after", 64'(run), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_page_scanner.md
BCD_PAGE_SCANNER -- requirements
Module: bcd_page_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 11: number of BCD digits in bcd_in.
REQ-002 Parameter DISP_DIGITS, default 3: digits shown per page.
REQ-003 Parameter PAGE_TICKS, default 50_000_000: CLOCK_50 cycles per page, minimum 1.
REQ-004 Parameter DEBOUNCE_TICKS, default 500_000: cycles a button level must be stable to be accepted, minimum 1.
REQ-005 Derived constant PAGES = ceil(NUM_DIGITS/DISP_DIGITS), with PW = max(1, clog2(PAGES)).
REQ-006 Port CLOCK_50 (in, 1): clock; all state on its rising edge.
REQ-007 Port reset_n (in, 1): reset, asynchronous, active-low.
REQ-008 Port bcd_in (in, 4*NUM_DIGITS): digit k at bits [4k+3:4k], with k=0 the least significant.
REQ-009 Port btn_n (in, 1): raw, asynchronous, active-low start/stop button.
REQ-010 Port scan_hold (in, 1): freezes the page rotation while high.
REQ-011 Port disp_bcd (out, 4*DISP_DIGITS): registered digits of the current page; code 4'hF means blank.
REQ-012 Port page_idx (out, PW): current page number.
REQ-013 Port page_seg (out, 7): active-low glyph of page_idx, bit6=g … bit0=a.
REQ-014 Port run (out, 1): start/stop toggle state.
REQ-015 Port page_strobe (out, 1): one-cycle pulse on each page change.

Function
REQ-016 Page timer SHALL count 0..PAGE_TICKS-1 and wrap, with terminal count at PAGE_TICKS-1.
REQ-017 On the terminal count with scan_hold=0, the block SHALL, on the same edge:
- pulse page_strobe;
- set page_idx to next(page_idx);
- load disp_bcd with the newly selected page.
REQ-018 Page order next(): PAGES-1, PAGES-2, …, 0, then wrap to PAGES-1 (most significant page first).
REQ-019 Page p, display slot j SHALL be bcd_in digit p*DISP_DIGITS+j, sampled at the loading edge. Positions at or above NUM_DIGITS SHALL be 4'hF.
REQ-020 disp_bcd SHALL change only on page_strobe edges; bcd_in changes between strobes SHALL NOT appear on disp_bcd.
REQ-021 scan_hold=1 SHALL stop the timer at its current value and SHALL suppress page_strobe. Hold beats a coincident terminal count. Counting SHALL resume from the held value when scan_hold drops.
REQ-022 With PAGE_TICKS=1, page_strobe SHALL assert every unheld cycle.
REQ-023 btn_n SHALL pass through a 2-flop synchronizer and then a debouncer. The debounced level SHALL change only after the synchronized level has differed from it for DEBOUNCE_TICKS consecutive cycles. Any bounce SHALL restart the count.
REQ-024 Each debounced 1->0 transition SHALL invert run, exactly once per press, 1 cycle after the debounced change. Release SHALL have no effect.
REQ-025 page_seg SHALL be the hex glyph of page_idx from the package table. page_idx values of 16 or more SHALL give 7'h7F (all off).
REQ-026 run and scan_hold are independent; the button SHALL NOT affect the scan.

Reset
REQ-027 reset_n low SHALL immediately set all state and outputs as follows:
- page timer = 0;
- page_idx = 0;
- disp_bcd = all 4'hF;
- page_strobe = 0;
- run = 1;
- debounced level = 1;
- debounce counter = 0;
- synchronizer = 1.
REQ-028 Reset asserted mid-debounce or mid-page SHALL discard the partial count. The first strobe after reset SHALL show page PAGES-1, PAGE_TICKS cycles after release.

Configuration
REQ-029 Macro LEADING_ZERO_BLANK_EN, when defined: at each load, every slot whose digit index is above the highest nonzero digit of the sampled bcd_in SHALL be 4'hF. Digit 0 is never blanked, so all-zero input shows a single "0". When not defined, zeros SHALL be shown as 4'h0 (the padding of REQ-019 still applies).

Structure
REQ-030 Package bcd_scan_pkg SHALL hold:
- BLANK_CODE = 4'hF;
- the 16-entry active-low hex glyph table;
- a clog2 function.
REQ-031 Synchronizer, debouncer and falling-edge detect SHALL be sub-module btn_debounce (parameter DEBOUNCE_TICKS). Timer and paging SHALL stay in the top module.

Verification (NUM_DIGITS=11, DISP_DIGITS=3, PAGE_TICKS=4, DEBOUNCE_TICKS=3)
REQ-032 Page scan: bcd_in=digits 0..10 → strobes every 4 cycles; page_idx sequence 3,2,1,0,3. Page 3 disp_bcd = {F,10,9}; page 0 = {2,1,0}.
REQ-033 Hold: scan_hold=1 for 10 cycles at timer=2 → no strobe; next strobe 2 cycles after release.
REQ-034 Button: btn_n low 2 cycles then high → run unchanged. btn_n low 6 cycles → run 1→0 once, and stays 0 after release.
REQ-035 Reset mid-scan at page 1 → immediately page_idx=0, disp_bcd=FFF, run=1; first strobe 4 cycles after release shows page 3.
REQ-036 LEADING_ZERO_BLANK_EN with bcd_in=decimal 42 → page 0 = {F,4,2}, pages 3..1 all F. With bcd_in=0 → page 0 = {F,F,0}. Without the macro, bcd_in=42 → page 0 = {0,4,2}.
